serial_compare_ctrl: RTL and testbench

//  Sequencer that compares two WIDTH-bit operands MSB-first, one 2-bit slice
//  per clock, using the team's 2-bit magnitude-compare slice rule.

---
 rtl/serial_compare_ctrl.sv | 133 +++++++++++++
 tb/tb_serial_compare_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_compare_ctrl.sv
// Purpose: MSB-first magnitude compare of two WIDTH-bit operands, one 2-bit slice per clock.
// Latency: done pulses the cycle after the deciding slice edge; 1..WIDTH/2 RUN cycles after start.
// Backpressure: none; start is only accepted in IDLE, and a start while busy or done is dropped.
module serial_compare_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             equal,
  output logic             lesser
);

  localparam int NSLICE = WIDTH / 2;
  // Keep the index at least one bit wide so a 2-bit operand still elaborates.
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]      slice_a;
  logic [1:0]      slice_b;

  // Control strobes from the FSM to the datapath registers.
  logic accept;
  logic step;
  logic set_gt;
  logic set_lt;
  logic set_eq;
  logic clr_flags;

  // The current slice comes from the captured operands, never from the live inputs.
  always_comb begin
    slice_a = op_a[{idx, 1'b0} +: 2];
    slice_b = op_b[{idx, 1'b0} +: 2];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control decode. In RUN, abort outranks the compare on the same edge.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    set_gt    = 1'b0;
    set_lt    = 1'b0;
    set_eq    = 1'b0;
    clr_flags = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          clr_flags = 1'b1;
          state_nxt = S_IDLE;
        end else if (slice_a > slice_b) begin
          set_gt    = 1'b1;
          state_nxt = S_DONE;
        end else if (slice_a < slice_b) begin
          set_lt    = 1'b1;
          state_nxt = S_DONE;
        end else if (idx == '0) begin
          set_eq    = 1'b1;
          state_nxt = S_DONE;
        end else begin
          step      = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, slice index and sticky result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      idx     <= '0;
      greater <= 1'b0;
      equal   <= 1'b0;
      lesser  <= 1'b0;
    end else begin
      if (accept) begin
        op_a    <= a;
        op_b    <= b;
        idx     <= IW'(NSLICE - 1);
        greater <= 1'b0;
        equal   <= 1'b0;
        lesser  <= 1'b0;
      end
      if (step)   idx     <= idx - 1'b1;
      if (set_gt) greater <= 1'b1;
      if (set_lt) lesser  <= 1'b1;
      if (set_eq) equal   <= 1'b1;
      if (clr_flags) begin
        greater <= 1'b0;
        equal   <= 1'b0;
        lesser  <= 1'b0;
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl (WIDTH=8): directed cases plus randomized compares.
// The reference compares whole operands and finds the first differing slice from the top bit down.
module tb_serial_compare_ctrl;

  localparam int NSLICE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, greater, equal, lesser;

  int checks   = 0;
  int failures = 0;

  serial_compare_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .a(a), .b(b),
    .busy(busy), .done(done), .greater(greater), .equal(equal), .lesser(lesser)
  );

  always #5 clk = ~clk;

  // Number of RUN edges needed: position of the first differing 2-bit slice counted from the MSB, plus one.
  function automatic int ref_lat(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d;
    d = x ^ y;
    for (int p = 7; p >= 0; p--)
      if (d[p]) return NSLICE - p / 2;
    return NSLICE;
  endfunction

  function automatic logic [2:0] ref_flags(input logic [7:0] x, input logic [7:0] y);
    return {x > y, x == y, x < y};
  endfunction

  // Drives one compare from IDLE and observes it.
  // lat: edge count after T0 at which done is seen, -2 if it fell back to IDLE without done, -1 on timeout.
  task automatic run_cmp(input logic [7:0] av, input logic [7:0] bv,
                         input bit pert, input logic [7:0] pa,
                         input int abort_k, input int rst_k,
                         input bit rst_on_done, input bit start_in_done,
                         output int lat, output int bcnt,
                         output logic [2:0] fl, output logic [2:0] fl_next,
                         output logic done_next, output logic busy_next);
    int k;
    bit fin;
    a = av; b = bv; start = 1'b1; abort = (abort_k == -2);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    k = 0; lat = -1; bcnt = 0; fin = 0;
    fl = 3'b000; fl_next = 3'b000; done_next = 1'b0; busy_next = 1'b0;
    while (!fin && k < 40) begin
      if (done) begin
        lat = k;
        fl = {greater, equal, lesser};
        start = 1'b0; abort = 1'b0;
        rst = rst_on_done;
        if (start_in_done) begin
          start = 1'b1; a = 8'($urandom); b = 8'($urandom);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        fl_next = {greater, equal, lesser};
        done_next = done; busy_next = busy;
        fin = 1;
      end else if (!busy) begin
        lat = -2;
        fl = {greater, equal, lesser};
        fl_next = fl;
        fin = 1;
      end else begin
        bcnt++;
        if (pert && k == 0) begin a = pa; start = 1'b1; end
        else start = 1'b0;
        abort = (k == abort_k);
        rst   = (k == rst_k);
        @(posedge clk); #1;
        k++;
      end
    end
    abort = 1'b0; rst = 1'b0;
    if (!start_in_done) start = 1'b0;
  endtask

  // Reset state, reset beating a pending start, and reset clearing held flags in IDLE.
  task automatic test_reset();
    int lat, bcnt; logic [2:0] fl, fln; logic dn, bn;
    rst = 1'b1; start = 1'b1; a = 8'hC0; b = 8'h80;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, done, greater, equal, lesser} !== 5'b0) begin
      failures++; $display("FAIL reset_outputs: got %b expected 00000", {busy, done, greater, equal, lesser});
    end
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_idle_after: busy=%b expected 0", busy);
    end
    run_cmp(8'hC0, 8'h80, 0, 8'h00, -1, -1, 0, 0, lat, bcnt, fl, fln, dn, bn);
    checks++; if (fln !== 3'b100) begin
      failures++; $display("FAIL reset_pre_flags: got %b expected 100", fln);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({greater, equal, lesser} !== 3'b000) begin
      failures++; $display("FAIL reset_clears_flags: got %b expected 000", {greater, equal, lesser});
    end
  endtask

  // Worked examples 1-3: latency, busy length, flags, single-cycle done, flags held in IDLE.
  task automatic test_directed();
    logic [7:0] ta [3] = '{8'hA5, 8'hC0, 8'h34};
    logic [7:0] tb [3] = '{8'hA5, 8'h80, 8'h36};
    int         tl [3] = '{4, 1, 4};
    logic [2:0] tf [3] = '{3'b010, 3'b100, 3'b001};
    int lat, bcnt; logic [2:0] fl, fln; logic dn, bn;
    for (int i = 0; i < 3; i++) begin
      run_cmp(ta[i], tb[i], 0, 8'h00, -1, -1, 0, 0, lat, bcnt, fl, fln, dn, bn);
      checks++; if (lat !== tl[i]) begin
        failures++; $display("FAIL directed_lat case %0d: got %0d expected %0d", i, lat, tl[i]);
      end
      checks++; if (bcnt !== tl[i]) begin
        failures++; $display("FAIL directed_busy case %0d: got %0d expected %0d", i, bcnt, tl[i]);
      end
      checks++; if (fl !== tf[i]) begin
        failures++; $display("FAIL directed_flags case %0d: got %b expected %b", i, fl, tf[i]);
      end
      checks++; if (dn !== 1'b0 || bn !== 1'b0) begin
        failures++; $display("FAIL directed_done_pulse case %0d: done=%b busy=%b expected 0 0", i, dn, bn);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({greater, equal, lesser} !== tf[i]) begin
        failures++; $display("FAIL directed_hold case %0d: got %b expected %b", i, {greater, equal, lesser}, tf[i]);
      end
    end
  endtask

  // Abort on the second RUN edge, abort on a deciding edge, start+abort together in IDLE.
  task automatic test_abort();
    int lat, bcnt; logic [2:0] fl, fln; logic dn, bn;
    run_cmp(8'h00, 8'h00, 0, 8'h00, 1, -1, 0, 0, lat, bcnt, fl, fln, dn, bn);
    checks++; if (lat !== -2 || bcnt !== 2 || fl !== 3'b000) begin
      failures++; $display("FAIL abort_run: lat=%0d busy=%0d flags=%b expected -2 2 000", lat, bcnt, fl);
    end
    run_cmp(8'h01, 8'h00, 0, 8'h00, -1, -1, 0, 0, lat, bcnt, fl, fln, dn, bn);
    checks++; if (lat !== 4 || fl !== 3'b100) begin
      failures++; $display("FAIL abort_then_start: lat=%0d flags=%b expected 4 100", lat, fl);
    end
    run_cmp(8'hC0, 8'h80, 0, 8'h00, 0, -1, 0, 0, lat, bcnt, fl, fln, dn, bn);
    checks++; if (lat !== -2 || bcnt !== 1 || fl !== 3'b000) begin
      failures++; $display("FAIL abort_priority: lat=%0d busy=%0d flags=%b expected -2 1 000", lat, bcnt, fl);
    end
    run_cmp(8'h34, 8'h36, 0, 8'h00, -2, -1, 0, 0, lat, bcnt, fl, fln, dn, bn);
    checks++; if (lat !== 4 || fl !== 3'b001) begin
      failures++; $display("FAIL abort_in_idle: lat=%0d flags=%b expected 4 001", lat, fl);
    end
  endtask

  // Operand change and start pulse during RUN must not disturb the captured compare.
  task automatic test_ignore_inputs();
    int lat, bcnt; logic [2:0] fl, fln; logic dn, bn;
    run_cmp(8'h10, 8'h20, 1, 8'hFF, -1, -1, 0, 0, lat, bcnt, fl, fln, dn, bn);
    checks++; if (lat !== 2 || fl !== 3'b001) begin
      failures++; $display("FAIL ignore_inputs: lat=%0d flags=%b expected 2 001", lat, fl);
    end
    checks++; if (bn !== 1'b0) begin
      failures++; $display("FAIL ignore_start_not_queued: busy=%b expected 0", bn);
    end
  endtask

  // Reset mid-RUN and on the done cycle.
  task automatic test_reset_mid_run();
    int lat, bcnt; logic [2:0] fl, fln; logic dn, bn;
    run_cmp(8'hA5, 8'hA5, 0, 8'h00, -1, 2, 0, 0, lat, bcnt, fl, fln, dn, bn);
    checks++; if (lat !== -2 || bcnt !== 3 || {busy, done, greater, equal, lesser} !== 5'b0) begin
      failures++; $display("FAIL reset_mid_run: lat=%0d busy_cnt=%0d outs=%b expected -2 3 00000",
                           lat, bcnt, {busy, done, greater, equal, lesser});
    end
    run_cmp(8'hA5, 8'hA5, 0, 8'h00, -1, -1, 0, 0, lat, bcnt, fl, fln, dn, bn);
    checks++; if (lat !== 4 || fl !== 3'b010) begin
      failures++; $display("FAIL reset_fresh_start: lat=%0d flags=%b expected 4 010", lat, fl);
    end
    run_cmp(8'hC0, 8'h80, 0, 8'h00, -1, -1, 1, 0, lat, bcnt, fl, fln, dn, bn);
    checks++; if (fl !== 3'b100 || fln !== 3'b000 || dn !== 1'b0) begin
      failures++; $display("FAIL reset_on_done: flags=%b after=%b done=%b expected 100 000 0", fl, fln, dn);
    end
  endtask

  // start held through DONE is dropped; the next compare follows straight after.
  task automatic test_back_to_back();
    int lat, bcnt; logic [2:0] fl, fln; logic dn, bn;
    logic [7:0] x, y;
    for (int i = 0; i < 6; i++) begin
      x = 8'($urandom); y = (i % 2 == 0) ? x : 8'($urandom);
      run_cmp(x, y, 0, 8'h00, -1, -1, 0, 1, lat, bcnt, fl, fln, dn, bn);
      checks++; if (lat !== ref_lat(x, y) || fl !== ref_flags(x, y)) begin
        failures++; $display("FAIL b2b_result %0d: lat=%0d flags=%b expected %0d %b", i, lat, fl, ref_lat(x, y), ref_flags(x, y));
      end
      checks++; if (bn !== 1'b0 || dn !== 1'b0) begin
        failures++; $display("FAIL b2b_start_in_done %0d: busy=%b done=%b expected 0 0", i, bn, dn);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  // Random operands (biased toward shared prefixes), random aborts and RUN-time perturbation.
  task automatic test_random();
    int lat, bcnt, ak, el, eb; logic [2:0] fl, fln, ef; logic dn, bn;
    logic [7:0] x, y;
    for (int i = 0; i < 80; i++) begin
      x = 8'($urandom);
      case ($urandom_range(0, 2))
        0: y = x;
        1: y = x ^ (8'h01 << $urandom_range(0, 7));
        default: y = 8'($urandom);
      endcase
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) - 2 : -1;
      el = ref_lat(x, y); eb = el; ef = ref_flags(x, y);
      if (ak >= 0 && ak < el) begin el = -2; eb = ak + 1; ef = 3'b000; end
      run_cmp(x, y, 1'($urandom), 8'($urandom), ak, -1, 0, 0, lat, bcnt, fl, fln, dn, bn);
      checks++; if (lat !== el || bcnt !== eb) begin
        failures++; $display("FAIL rand_timing %0d a=%h b=%h abort_k=%0d: lat=%0d busy=%0d expected %0d %0d",
                             i, x, y, ak, lat, bcnt, el, eb);
      end
      checks++; if (fl !== ef || fln !== ef) begin
        failures++; $display("FAIL rand_flags %0d a=%h b=%h: got %b/%b expected %b", i, x, y, fl, fln, ef);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_ignore_inputs();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
